alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer_if.sv | 26 ++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU operand/result bus for the 8-bit CPU sequencer.
interface alu_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       alu_en;
  logic [2:0] alu_opcode;
  logic [3:0] alu_in_1;
  logic [3:0] alu_in_2;
  logic [3:0] alu_result;
  logic       done;
  logic [3:0] result;
  logic       zero;

  // Sequencer side: consumes instructions, owns every ALU input
  modport master (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2, done, result, zero
  );

  // Environment side: instruction source plus the registered ALU
  modport slave (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2, done, result, zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction, snapshots two operands from a
// 4x4 register file, issues a single enabled ALU operation, then reports
// the result and optionally writes it back. One instruction per 3 cycles.
module alu_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.master  bus,
  input  logic             i_ld_en,
  input  logic [1:0]       i_ld_addr,
  input  logic [3:0]       i_ld_data,
  input  logic [1:0]       i_rd_addr,
  output logic [3:0]       o_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [3:0] r_rf [4];
  logic [1:0] r_rd;
  logic       r_wb;
  logic [2:0] r_alu_opcode;
  logic [3:0] r_alu_in_1;
  logic [3:0] r_alu_in_2;

  logic [2:0] w_opcode;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic       w_wb;
  logic       w_accept;

  assign w_opcode = bus.instr[7:5];
  assign w_rd     = bus.instr[4:3];
  assign w_rs     = bus.instr[2:1];
  assign w_wb     = bus.instr[0];
  assign w_accept = bus.instr_valid && (r_state == IDLE);

  assign o_rd_data = r_rf[i_rd_addr];

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: IDLE waits for an accept, ISSUE and WB last one cycle each
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ISSUE;
      ISSUE:   w_next_state = WB;
      WB:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; result and zero are forced to 0 outside WB
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.alu_en      = 1'b0;
    bus.done        = 1'b0;
    bus.result      = 4'd0;
    bus.zero        = 1'b0;
    case (r_state)
      IDLE: begin
        bus.instr_ready = 1'b1;
      end
      ISSUE: begin
        bus.alu_en = 1'b1;
      end
      WB: begin
        bus.done   = 1'b1;
        bus.result = bus.alu_result;
        bus.zero   = (bus.alu_result == 4'd0);
      end
      default: begin
        bus.instr_ready = 1'b0;
      end
    endcase
  end

  assign bus.alu_opcode = r_alu_opcode;
  assign bus.alu_in_1   = r_alu_in_1;
  assign bus.alu_in_2   = r_alu_in_2;

  // Datapath: operand snapshot on accept (old register values), then load
  // port write, then writeback, so writeback wins a same-register collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= 4'd0;
      end
      r_rd         <= 2'd0;
      r_wb         <= 1'b0;
      r_alu_opcode <= 3'd0;
      r_alu_in_1   <= 4'd0;
      r_alu_in_2   <= 4'd0;
    end else begin
      if (w_accept) begin
        r_rd         <= w_rd;
        r_wb         <= w_wb;
        r_alu_opcode <= w_opcode;
        r_alu_in_1   <= r_rf[w_rd];
        r_alu_in_2   <= r_rf[w_rs];
      end
      if (i_ld_en) begin
        r_rf[i_ld_addr] <= i_ld_data;
      end
      if ((r_state == WB) && r_wb) begin
        r_rf[r_rd] <= bus.alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a small registered ALU model.
module tb_alu_sequencer;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;

  int checkCount  = 0;
  int errorCount  = 0;
  int acceptCount = 0;
  int aluEnCount  = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .i_ld_en   (ld_en),
    .i_ld_addr (ld_addr),
    .i_ld_data (ld_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  always #5 clk = ~clk;

  // Registered ALU: samples its inputs on the edge ending the enabled cycle
  always @(posedge clk) begin
    if (bus.alu_en) begin
      case (bus.alu_opcode)
        OP_AND:  bus.alu_result <= bus.alu_in_1 & bus.alu_in_2;
        OP_ADD:  bus.alu_result <= bus.alu_in_1 + bus.alu_in_2;
        OP_SUB:  bus.alu_result <= bus.alu_in_1 - bus.alu_in_2;
        OP_XOR:  bus.alu_result <= bus.alu_in_1 ^ bus.alu_in_2;
        OP_SHL:  bus.alu_result <= bus.alu_in_1 << bus.alu_in_2[1:0];
        default: bus.alu_result <= 4'd0;
      endcase
    end
  end

  // Handshake monitor: counts accepts and ALU enable pulses per edge
  always @(posedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) acceptCount++;
    if (rst_n && bus.alu_en) aluEnCount++;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs, input logic wb);
    return {op, rd, rs, wb};
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic loadReg(input logic [1:0] a, input logic [3:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [1:0] a, input logic [3:0] expected);
    rd_addr = a;
    #1;
    checkOutput(tag, rd_data, expected);
  endtask

  // ldPhase: 0 = no load, 1 = load on the accept edge, 2 = load on the WB edge
  task automatic applyStimulus(input string tag, input logic [7:0] ins,
                               input logic [3:0] expIn1, input logic [3:0] expIn2,
                               input logic [3:0] expResult, input logic expZero,
                               input int ldPhase, input logic [1:0] lA, input logic [3:0] lD);
    int waitCycles = 0;
    while (!bus.instr_ready && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.instr_ready) begin
      checkOutput({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    if (ldPhase == 1) begin
      ld_en = 1'b1; ld_addr = lA; ld_data = lD;
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    ld_en           = 1'b0;
    checkOutput({tag, "_issue_alu_en"}, bus.alu_en, 1);
    checkOutput({tag, "_issue_ready"}, bus.instr_ready, 0);
    checkOutput({tag, "_issue_done"}, bus.done, 0);
    checkOutput({tag, "_opcode"}, bus.alu_opcode, ins[7:5]);
    checkOutput({tag, "_in1"}, bus.alu_in_1, expIn1);
    checkOutput({tag, "_in2"}, bus.alu_in_2, expIn2);
    @(negedge clk);
    if (ldPhase == 2) begin
      ld_en = 1'b1; ld_addr = lA; ld_data = lD;
    end
    checkOutput({tag, "_wb_done"}, bus.done, 1);
    checkOutput({tag, "_wb_alu_en"}, bus.alu_en, 0);
    checkOutput({tag, "_result"}, bus.result, expResult);
    checkOutput({tag, "_zero"}, bus.zero, expZero);
    @(negedge clk);
    ld_en = 1'b0;
    checkOutput({tag, "_idle_done"}, bus.done, 0);
    checkOutput({tag, "_idle_ready"}, bus.instr_ready, 1);
  endtask

  // Directed sequence of all scenarios, ending in the summary line
  initial begin
    int startAcc;
    int startEn;
    logic [3:0] b2bExp [3];
    b2bExp[0] = 4'd2;
    b2bExp[1] = 4'd8;
    b2bExp[2] = 4'd6;

    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 8'd0;
    ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'd0; rd_addr = 2'd0;

    repeat (2) @(negedge clk);
    checkOutput("rst_alu_en", bus.alu_en, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_result", bus.result, 0);
    checkOutput("rst_zero", bus.zero, 0);
    checkOutput("rst_in1", bus.alu_in_1, 0);
    checkOutput("rst_opcode", bus.alu_opcode, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", bus.instr_ready, 1);
    for (int i = 0; i < 4; i++) checkReg($sformatf("rst_rf%0d", i), 2'(i), 4'd0);

    // ADD r1=3 + r2=5 with writeback
    loadReg(2'd1, 4'd3);
    loadReg(2'd2, 4'd5);
    applyStimulus("add", 8'b001_01_10_1, 4'd3, 4'd5, 4'd8, 1'b0, 0, 2'd0, 4'd0);
    checkReg("add_r1", 2'd1, 4'd8);

    // SUB wraps: 3 - 5 = 14, no writeback
    loadReg(2'd1, 4'd3);
    applyStimulus("sub", mk(OP_SUB, 2'd1, 2'd2, 1'b0), 4'd3, 4'd5, 4'd14, 1'b0, 0, 2'd0, 4'd0);
    checkReg("sub_r1", 2'd1, 4'd3);

    // SHL r0=0111 by r3=2 gives 1100
    loadReg(2'd0, 4'd7);
    loadReg(2'd3, 4'd2);
    applyStimulus("shl", mk(OP_SHL, 2'd0, 2'd3, 1'b0), 4'd7, 4'd2, 4'd12, 1'b0, 0, 2'd0, 4'd0);
    checkReg("shl_r0", 2'd0, 4'd7);

    // XOR r3,r3 = 0 sets zero, r3 unchanged
    applyStimulus("xor", mk(OP_XOR, 2'd3, 2'd3, 1'b0), 4'd2, 4'd2, 4'd0, 1'b1, 0, 2'd0, 4'd0);
    checkReg("xor_r3", 2'd3, 4'd2);

    // Load and writeback on the same register: writeback wins
    loadReg(2'd1, 4'd3);
    applyStimulus("coll_same", mk(OP_ADD, 2'd1, 2'd2, 1'b1), 4'd3, 4'd5, 4'd8, 1'b0, 2, 2'd1, 4'd9);
    checkReg("coll_same_r1", 2'd1, 4'd8);

    // Load and writeback on different registers: both land
    loadReg(2'd1, 4'd3);
    applyStimulus("coll_diff", mk(OP_ADD, 2'd1, 2'd2, 1'b1), 4'd3, 4'd5, 4'd8, 1'b0, 2, 2'd2, 4'd9);
    checkReg("coll_diff_r1", 2'd1, 4'd8);
    checkReg("coll_diff_r2", 2'd2, 4'd9);

    // Load on the accept edge: snapshot sees the old r2
    loadReg(2'd1, 4'd1);
    loadReg(2'd2, 4'd5);
    applyStimulus("rbw", mk(OP_ADD, 2'd1, 2'd2, 1'b0), 4'd1, 4'd5, 4'd6, 1'b0, 1, 2'd2, 4'd7);
    checkReg("rbw_r2", 2'd2, 4'd7);

    // Back-to-back: valid held high, instruction changing every cycle
    loadReg(2'd0, 4'd1);
    loadReg(2'd1, 4'd2);
    loadReg(2'd2, 4'd3);
    loadReg(2'd3, 4'd4);
    startAcc = acceptCount;
    startEn  = aluEnCount;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("b2b_ready%0d", i), bus.instr_ready, (i % 3 == 0) ? 1 : 0);
      checkOutput($sformatf("b2b_done%0d", i), bus.done, (i % 3 == 2) ? 1 : 0);
      if (i % 3 == 2) checkOutput($sformatf("b2b_result%0d", i), bus.result, b2bExp[i / 3]);
      bus.instr_valid = 1'b1;
      bus.instr       = mk(OP_ADD, 2'(i % 4), 2'(i % 4), 1'b0);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_accepts", acceptCount - startAcc, 3);
    checkOutput("b2b_alu_en_pulses", aluEnCount - startEn, 3);

    // Reset during ISSUE aborts the instruction
    loadReg(2'd1, 4'd3);
    loadReg(2'd2, 4'd5);
    bus.instr_valid = 1'b1;
    bus.instr       = mk(OP_ADD, 2'd1, 2'd2, 1'b1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    checkOutput("rsti_alu_en_before", bus.alu_en, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rsti_alu_en", bus.alu_en, 0);
    checkOutput("rsti_opcode", bus.alu_opcode, 0);
    checkOutput("rsti_in1", bus.alu_in_1, 0);
    checkOutput("rsti_in2", bus.alu_in_2, 0);
    checkOutput("rsti_done", bus.done, 0);
    checkOutput("rsti_result", bus.result, 0);
    checkOutput("rsti_zero", bus.zero, 0);
    for (int i = 0; i < 4; i++) checkReg($sformatf("rsti_rf%0d", i), 2'(i), 4'd0);
    @(negedge clk);
    checkOutput("rsti_done_held", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rsti_done_after", bus.done, 0);
    checkReg("rsti_r1_after", 2'd1, 4'd0);
    loadReg(2'd1, 4'd2);
    loadReg(2'd2, 4'd2);
    applyStimulus("post_rst", mk(OP_ADD, 2'd1, 2'd2, 1'b1), 4'd2, 4'd2, 4'd4, 1'b0, 0, 2'd0, 4'd0);
    checkReg("post_rst_r1", 2'd1, 4'd4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
